// File: rtl/debounce_edge_pkg.sv
// debounce_edge_pkg: shared FSM state encoding; bit 1 is the accepted level, bit 0 means qualifying
package debounce_edge_pkg;
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b10,
    QUAL_LO   = 2'b11
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; clear wins over the old value but keeps a coincident increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= W'(inc);
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: qualifies a synchronized level into a clean level, edge strobes and a rise counter
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   CNT_W           = 8,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             en,
  input  logic             clr_count,
  output logic             stable_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             busy
);
  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  state_t        state;
  logic [QW-1:0] cnt, cnt_nxt;
  logic          hi, cand, acc;
  assign hi      = state[1];
  assign cand    = sync_in != hi;
  assign cnt_nxt = cnt + 1'b1;
  // cnt holds how many consecutive samples of the new level have been seen
  assign acc     = cand && cnt_nxt == QW'(DEBOUNCE_CYCLES);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= en && acc && !hi;
      fall_pulse <= en && acc && hi;
      if (!en || !cand) begin
        state <= hi ? STABLE_HI : STABLE_LO;
        cnt   <= '0;
      end else if (acc) begin
        state <= hi ? STABLE_LO : STABLE_HI;
        cnt   <= '0;
      end else begin
        state <= hi ? QUAL_LO : QUAL_HI;
        cnt   <= cnt_nxt;
      end
    end
  assign stable_out = state[1];
  assign busy       = state[0];
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(rise_pulse),
    .clr(clr_count),
    .q(edge_count)
  );
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: scoreboard bench; observed vector is {stable, rise, fall, busy, edge_count}
module tb_debounce_edge;
  logic       clk = 1'b0, rst = 1'b1;
  logic       sync_in = 1'b0, en = 1'b1, clr_count = 1'b0;
  logic       stable_out, rise_pulse, fall_pulse, busy;
  logic [2:0] edge_count;
  logic       sync2 = 1'b1, en2 = 1'b1, clr2 = 1'b0;
  logic       stable2, rise2, fall2, busy2;
  logic [2:0] count2;
  logic [6:0] obs, obs2;
  logic [6:0] q[$];
  int         vectors = 0, miscompares = 0;

  debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .sync_in(sync_in), .en(en), .clr_count(clr_count),
    .stable_out(stable_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .edge_count(edge_count), .busy(busy)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(1), .CNT_W(3), .INIT_LEVEL(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .sync_in(sync2), .en(en2), .clr_count(clr2),
    .stable_out(stable2), .rise_pulse(rise2), .fall_pulse(fall2),
    .edge_count(count2), .busy(busy2)
  );

  assign obs  = {stable_out, rise_pulse, fall_pulse, busy, edge_count};
  assign obs2 = {stable2, rise2, fall2, busy2, count2};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    logic [6:0] e;
    for (int k = 1; k <= 2; k++) begin
      sync_in = 1'b1;
      q.push_back(7'b0001000);
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset_pre k=%0d got %b exp %b", k, obs, e); end
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 7'b0000000) begin miscompares++; $display("FAIL reset_async got %b exp %b", obs, 7'b0); end
    vectors++;
    if (obs2 !== 7'b1000000) begin miscompares++; $display("FAIL reset_async_hi got %b exp %b", obs2, 7'b1000000); end
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      sync_in = 1'b1;
      q.push_back({(k >= 4), (k == 4), 1'b0, (k < 4), ((k >= 5) ? 3'd1 : 3'd0)});
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL reset_rise k=%0d got %b exp %b", k, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_fall();
    logic [6:0] e;
    for (int k = 1; k <= 5; k++) begin
      sync_in = 1'b0;
      q.push_back({(k < 4), 1'b0, (k == 4), (k < 4), 3'd1});
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL fall k=%0d got %b exp %b", k, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_bounce();
    logic [6:0] e;
    logic       pat[9];
    logic       bsy[9];
    pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    bsy = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      sync_in = pat[i];
      q.push_back({(i >= 7), (i == 7), 1'b0, bsy[i], ((i == 8) ? 3'd2 : 3'd1)});
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL bounce i=%0d got %b exp %b", i, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    logic [6:0] e;
    logic [2:0] c;
    int         j;
    c = 3'd2;
    for (int r = 0; r < 9; r++)
      for (int k = 1; k <= 10; k++) begin
        sync_in = (k > 5);
        j = k - 5;
        if (k <= 5) e = {(k < 4), 1'b0, (k == 4), (k < 4), c};
        else begin
          if (j == 5 && c != 3'd7) c = c + 3'd1;
          e = {(j >= 4), (j == 4), 1'b0, (j < 4), c};
        end
        q.push_back(e);
        @(posedge clk); #1;
        e = q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL saturate r=%0d k=%0d got %b exp %b", r, k, obs, e); end
        @(negedge clk);
      end
  endtask

  task automatic test_clear();
    logic [6:0] e;
    for (int k = 1; k <= 11; k++) begin
      sync_in = (k > 5);
      clr_count = (k == 10);
      j_block: begin
        int j;
        j = k - 5;
        if (k <= 5) e = {(k < 4), 1'b0, (k == 4), (k < 4), 3'd7};
        else e = {(j >= 4), (j == 4), 1'b0, (j < 4), ((j >= 5) ? 3'd1 : 3'd7)};
      end
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL clear_coincident k=%0d got %b exp %b", k, obs, e); end
      @(negedge clk);
    end
    for (int k = 1; k <= 2; k++) begin
      clr_count = (k == 1);
      q.push_back(7'b1000000);
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL clear_idle k=%0d got %b exp %b", k, obs, e); end
      @(negedge clk);
    end
    clr_count = 1'b0;
  endtask

  task automatic test_enable();
    logic [6:0] e;
    for (int k = 1; k <= 15; k++) begin
      sync_in = (k > 5);
      en = !(k >= 8 && k <= 10);
      if (k <= 5) e = {(k < 4), 1'b0, (k == 4), (k < 4), 3'd0};
      else if (k <= 7) e = 7'b0001000;
      else if (k <= 10) e = 7'b0000000;
      else e = {(k >= 14), (k == 14), 1'b0, (k < 14), ((k >= 15) ? 3'd1 : 3'd0)};
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL enable k=%0d got %b exp %b", k, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_init_high();
    logic [6:0] e;
    logic       pat[5];
    logic [6:0] exp_v[5];
    pat   = '{1, 0, 1, 1, 1};
    exp_v = '{7'b1000000, 7'b0010000, 7'b1100000, 7'b1000001, 7'b1000001};
    for (int i = 0; i < 5; i++) begin
      sync2 = pat[i];
      q.push_back(exp_v[i]);
      @(posedge clk); #1;
      e = q.pop_front(); vectors++;
      if (obs2 !== e) begin miscompares++; $display("FAIL init_high i=%0d got %b exp %b", i, obs2, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_fall();
    test_bounce();
    test_saturate();
    test_clear();
    test_enable();
    test_init_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
